// File: rtl/mem_interface.sv
// Memory access sequencer between a multicycle control FSM and an external memory.
// Latches one request, waits for mem_ready with a timeout, and steers read data to instr or mdr.
module mem_interface #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        ior_d,
  input  logic        ir_write,
  input  logic [31:0] pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] mdr,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_e;

  localparam logic [7:0] WaitLimitC = 8'(WAIT_LIMIT);

  state_e      state_q;
  logic [7:0]  wait_q;
  logic [31:0] addr_q, wdata_q, instr_q, mdr_q;
  logic        we_q, irw_q, req_q, err_q;

  logic        access_d;
  logic [31:0] addr_d;

  always_comb begin
    access_d = mem_read | mem_write;
    addr_d   = ior_d ? alu_out : pc;
  end

  // NOTE: stall is qualified by reset so it drops the instant reset asserts, even while a request is pending.
  assign stall = reset & (((state_q == IDLE) && access_d) || (state_q == REQ) || (state_q == ERR));

  // NOTE: every state element, data registers included, is cleared by the async reset; all updates use <=.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      instr_q <= '0;
      mdr_q   <= '0;
      we_q    <= 1'b0;
      irw_q   <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access_d) begin
            addr_q  <= addr_d;
            wdata_q <= store_data;
            we_q    <= mem_write;
            irw_q   <= ir_write;
            wait_q  <= '0;
            // Simultaneous read and write: the write wins and the conflict is flagged.
            if (mem_read && mem_write) err_q <= 1'b1;
            if (addr_d[1:0] != 2'b00) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= REQ;
              req_q   <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            if (!we_q) begin
              if (irw_q) instr_q <= mem_rdata;
              else       mdr_q   <= mem_rdata;
            end
            req_q   <= 1'b0;
            state_q <= DONE;
          end else if (wait_q == WaitLimitC) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ERR;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        DONE:    state_q <= IDLE;
        ERR:     state_q <= ERR;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign instr     = instr_q;
  assign mdr       = mdr_q;
  assign err       = err_q;
  assign opcode    = instr_q[6:0];
  assign funct3    = instr_q[14:12];
  assign funct7    = instr_q[31:25];

endmodule
